data_memory_dp: RTL and testbench

Parametrised dual-port data memory: one synchronous write port with byte enables and one synchronous read port, both on a single clock. It succeeds the fixed 64x1024 data memory in the datapath and adds configurable width and depth, byte-granular writes, and a defined read/write collision policy. It also adds a hardware clear sweep after reset and a read-valid strobe. It sits between the load/store unit and the register write-back path.

---
 rtl/data_memory_dp_if.sv | 27 ++
 rtl/data_memory_dp.sv | 132 +++++++++++++
 tb/tb_data_memory_dp.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_dp_if.sv
// Request/response bundle for data_memory_dp: write port, read port and status.
// master = load/store side driving requests, slave = the memory.
interface data_memory_dp_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
);
    logic                  wr;
    logic [ADDR_W-1:0]     write_adr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W/8-1:0]   byte_en;
    logic                  rd;
    logic [ADDR_W-1:0]     read_adr;
    logic [DATA_W-1:0]     data_out;
    logic                  rd_valid;
    logic                  busy;
    logic                  oor_err;

    modport master (
        output wr, write_adr, data_in, byte_en, rd, read_adr,
        input  data_out, rd_valid, busy, oor_err
    );

    modport slave (
        input  wr, write_adr, data_in, byte_en, rd, read_adr,
        output data_out, rd_valid, busy, oor_err
    );
endinterface

// File: rtl/data_memory_dp.sv
// Dual-port data memory with byte-enabled writes, a post-reset clear sweep and read-valid strobe.
// Optional macro DMEM_OUT_REG_EN adds a second output register stage (read latency 2).
module data_memory_dp #(
    parameter int                DATA_W      = 64,
    parameter int                DEPTH       = 1024,
    parameter int                ADDR_W      = $clog2(DEPTH),
    parameter int                COLLISION   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input logic            clk,
    input logic            rst_n,
    data_memory_dp_if.slave bus
);
    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_adr_q, clr_adr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run, wr_ok, rd_ok, wr_en, rd_en;
    logic                vld_d, oor_d;
    logic [DATA_W-1:0]   rdata, dout_d;
    logic [DATA_W-1:0]   dout_p1_q;
    logic                vld_p1_q, oor_p1_q;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= CLEAR;
            clr_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_adr_q <= clr_adr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_adr_d = clr_adr_q;
        if (state_q == CLEAR) begin
            clr_adr_d = clr_adr_q + 1'b1;
            if (clr_adr_q == LAST_ADR) begin
                state_d   = RUN;
                clr_adr_d = '0;
            end
        end
    end

    // Request decode: nothing is accepted while the sweep runs, addresses never wrap.
    always_comb begin
        run   = (state_q == RUN);
        wr_ok = ({1'b0, bus.write_adr} < DEPTH_L);
        rd_ok = ({1'b0, bus.read_adr} < DEPTH_L);
        wr_en = run && bus.wr && wr_ok;
        rd_en = run && bus.rd && rd_ok;
        vld_d = run && bus.rd;
        oor_d = run && ((bus.wr && !wr_ok) || (bus.rd && !rd_ok));
        rdata = '0;
        if (rd_en) begin
            rdata = mem_q[bus.read_adr];
            if (COLLISION != 0 && wr_en && bus.write_adr == bus.read_adr)
                rdata = merge_bytes(rdata, bus.data_in, bus.byte_en);
        end
        dout_d = vld_d ? rdata : dout_p1_q;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == CLEAR)
                mem_q[clr_adr_q] <= CLEAR_VALUE;
            else if (wr_en)
                mem_q[bus.write_adr] <= merge_bytes(mem_q[bus.write_adr], bus.data_in, bus.byte_en);
        end
    end

    // Stage p1: first output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_p1_q <= '0;
            vld_p1_q  <= 1'b0;
            oor_p1_q  <= 1'b0;
        end else begin
            dout_p1_q <= dout_d;
            vld_p1_q  <= vld_d;
            oor_p1_q  <= oor_d;
        end
    end

`ifdef DMEM_OUT_REG_EN
    logic [DATA_W-1:0] dout_p2_q;
    logic              vld_p2_q, oor_p2_q;

    // Stage p2: optional retiming register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_p2_q <= '0;
            vld_p2_q  <= 1'b0;
            oor_p2_q  <= 1'b0;
        end else begin
            dout_p2_q <= dout_p1_q;
            vld_p2_q  <= vld_p1_q;
            oor_p2_q  <= oor_p1_q;
        end
    end

    assign bus.data_out = dout_p2_q;
    assign bus.rd_valid = vld_p2_q;
    assign bus.oor_err  = oor_p2_q;
`else
    assign bus.data_out = dout_p1_q;
    assign bus.rd_valid = vld_p1_q;
    assign bus.oor_err  = oor_p1_q;
`endif

    assign bus.busy = (state_q == CLEAR);
endmodule

// File: tb/tb_data_memory_dp.sv
// Randomized bench for data_memory_dp: two instances (old-data and new-data collision policy,
// different clear values) share stimulus and are checked every cycle against a behavioural model.
module tb_data_memory_dp;
    localparam int          DW    = 64;
    localparam int          DEPTH = 12;
    localparam int          AW    = 4;
    localparam logic [63:0] CV0   = 64'h0;
    localparam logic [63:0] CV1   = 64'hDEAD_BEEF_0123_4567;
`ifdef DMEM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst_n;
    logic          wr, rd;
    logic [AW-1:0] write_adr, read_adr;
    logic [63:0]   data_in;
    logic [7:0]    byte_en;

    int checks = 0;
    int errors = 0;

    data_memory_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    data_memory_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    assign if0.wr = wr;         assign if1.wr = wr;
    assign if0.rd = rd;         assign if1.rd = rd;
    assign if0.write_adr = write_adr; assign if1.write_adr = write_adr;
    assign if0.read_adr  = read_adr;  assign if1.read_adr  = read_adr;
    assign if0.data_in = data_in;     assign if1.data_in = data_in;
    assign if0.byte_en = byte_en;     assign if1.byte_en = byte_en;

    data_memory_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .COLLISION(0), .CLEAR_VALUE(CV0))
        u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    data_memory_dp #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .COLLISION(1), .CLEAR_VALUE(CV1))
        u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mrg(input logic [63:0] o, input logic [63:0] d, input logic [7:0] be);
        for (int i = 0; i < 8; i++) if (be[i]) o[8*i +: 8] = d[8*i +: 8];
        return o;
    endfunction

    // Behavioural model: memory arrays per instance, sweep countdown, LAT-deep result history.
    logic [63:0] m0 [DEPTH];
    logic [63:0] m1 [DEPTH];
    int          sweep_left = 0;
    bit          model_live = 0;
    logic [63:0] h0 [1:LAT];
    logic [63:0] h1 [1:LAT];
    logic        hv [1:LAT];
    logic        ho [1:LAT];
    logic [63:0] n0, n1;
    logic        nv, no, wr_in, rd_in;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_live = 1;
            sweep_left = DEPTH;
            for (int k = 1; k <= LAT; k++) begin
                h0[k] = '0; h1[k] = '0; hv[k] = 1'b0; ho[k] = 1'b0;
            end
        end else if (model_live) begin
            n0 = h0[1]; n1 = h1[1]; nv = 1'b0; no = 1'b0;
            if (sweep_left > 0) begin
                m0[DEPTH - sweep_left] = CV0;
                m1[DEPTH - sweep_left] = CV1;
                sweep_left--;
            end else begin
                wr_in = wr && (int'(write_adr) < DEPTH);
                rd_in = rd && (int'(read_adr) < DEPTH);
                no = (wr && !wr_in) || (rd && !rd_in);
                if (rd) begin
                    nv = 1'b1;
                    if (rd_in) begin
                        n0 = m0[read_adr];
                        n1 = m1[read_adr];
                        if (wr_in && write_adr == read_adr) n1 = mrg(n1, data_in, byte_en);
                    end else begin
                        n0 = '0; n1 = '0;
                    end
                end
                if (wr_in) begin
                    m0[write_adr] = mrg(m0[write_adr], data_in, byte_en);
                    m1[write_adr] = mrg(m1[write_adr], data_in, byte_en);
                end
            end
            for (int k = LAT; k > 1; k--) begin
                h0[k] = h0[k-1]; h1[k] = h1[k-1]; hv[k] = hv[k-1]; ho[k] = ho[k-1];
            end
            h0[1] = n0; h1[1] = n1; hv[1] = nv; ho[1] = no;
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            chk("busy0", 64'(if0.busy), 64'(sweep_left > 0));
            chk("busy1", 64'(if1.busy), 64'(sweep_left > 0));
            chk("dout0", if0.data_out, h0[LAT]);
            chk("dout1", if1.data_out, h1[LAT]);
            chk("vld0",  64'(if0.rd_valid), 64'(hv[LAT]));
            chk("vld1",  64'(if1.rd_valid), 64'(hv[LAT]));
            chk("oor0",  64'(if0.oor_err), 64'(ho[LAT]));
            chk("oor1",  64'(if1.oor_err), 64'(ho[LAT]));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        wr = 1'b0; rd = 1'b0;
    endtask

    task automatic rd_lit(input logic [AW-1:0] a, input logic [63:0] e0, input logic [63:0] e1, input string nm);
        rd = 1'b1; read_adr = a; wr = 1'b0;
        step();
        rd = 1'b0;
        repeat (LAT - 1) step();
        chk({nm, "_d0"}, if0.data_out, e0);
        chk({nm, "_d1"}, if1.data_out, e1);
        chk({nm, "_v"}, 64'(if0.rd_valid), 64'd1);
    endtask

    task automatic wr_op(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
        wr = 1'b1; rd = 1'b0; write_adr = a; data_in = d; byte_en = be;
        step();
        wr = 1'b0;
    endtask

    task automatic count_sweep(input string nm);
        int n = 0;
        do begin
            wr = 1'($urandom); rd = 1'($urandom);
            write_adr = AW'($urandom_range(0, 15)); read_adr = AW'($urandom_range(0, 15));
            data_in = {$urandom, $urandom}; byte_en = 8'($urandom);
            step();
            n++;
        end while (if0.busy && n < 100);
        idle();
        chk(nm, 64'(n), 64'(DEPTH));
    endtask

    initial begin
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; write_adr = '0; read_adr = '0;
        data_in = '0; byte_en = '0;
        step(); step();
        chk("rst_busy", 64'(if0.busy), 64'd1);
        chk("rst_dout", if1.data_out, 64'd0);
        chk("rst_vld", 64'(if1.rd_valid), 64'd0);

        rst_n = 1'b1;
        count_sweep("sweep_len");
        for (int a = 0; a < DEPTH; a++) rd_lit(AW'(a), CV0, CV1, "clear_rd");

        wr_op(5, 64'h1122334455667788, 8'hFF);
        wr_op(5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd_lit(5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, "byte_en");

        wr_op(3, 64'h0, 8'hFF);
        wr = 1'b1; rd = 1'b1; write_adr = 3; read_adr = 3; data_in = 64'hFF; byte_en = 8'hFF;
        step();
        idle();
        repeat (LAT - 1) step();
        chk("coll_old", if0.data_out, 64'h0);
        chk("coll_new", if1.data_out, 64'hFF);
        rd_lit(3, 64'hFF, 64'hFF, "coll_after");

        wr_op(13, 64'h0123456789ABCDEF, 8'hFF);
        repeat (LAT - 1) step();
        chk("oor_wr", 64'(if0.oor_err), 64'd1);
        chk("oor_wr_vld", 64'(if0.rd_valid), 64'd0);
        step();
        chk("oor_wr_pulse", 64'(if0.oor_err), 64'd0);
        rd_lit(13, 64'h0, 64'h0, "oor_rd");
        chk("oor_rd_err", 64'(if1.oor_err), 64'd1);
        step();
        chk("oor_rd_pulse", 64'(if1.oor_err), 64'd0);
        rd_lit(1, CV0, CV1, "no_wrap");

        rd_lit(5, 64'h11223344AAAAAAAA, 64'h11223344AAAAAAAA, "pre_rst");
        rst_n = 1'b0;
        step();
        chk("rst_op_dout", if0.data_out, 64'h0);
        chk("rst_op_vld", 64'(if0.rd_valid), 64'd0);
        rst_n = 1'b1;
        repeat (7) step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_busy", 64'(if0.busy), 64'd1);
        chk("mid_rst_dout", if1.data_out, 64'h0);
        rst_n = 1'b1;
        count_sweep("resweep_len");

        for (int c = 0; c < 600; c++) begin
            wr = 1'($urandom); rd = 1'($urandom);
            write_adr = AW'($urandom_range(0, 15));
            read_adr  = ($urandom_range(0, 2) == 0) ? write_adr : AW'($urandom_range(0, 15));
            data_in = {$urandom, $urandom};
            byte_en = 8'($urandom);
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        idle();
        repeat (DEPTH + 4) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
